// File: rtl/ps2_fifo.sv
// Synchronous scan-code FIFO for the PS/2 receiver.
// Extra pointer MSB distinguishes full from empty.
`timescale 1ns/1ps
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_rdata  = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
        r_wrPtr <= r_wrPtr + (AW+1)'(1);
      end
      if (w_doPop) r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ps2_kbd.sv
// Receive-only PS/2 keyboard port: line filtering, frame deserialiser,
// scan-code FIFO and a two-register status/data CPU interface.
`timescale 1ns/1ps
module ps2_kbd #(
  parameter int FIFO_DEPTH = 8,
  parameter int FILT_LEN   = 8,
  parameter int TIMEOUT    = 16000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic       rs,
  input  logic       rdy,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       irq
);

  localparam int STAT_NE   = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_PERR = 2;
  localparam int STAT_FERR = 3;
  localparam int STAT_IEN  = 6;
  localparam int STAT_IRQ  = 7;
  localparam int CTRL_IEN  = 0;
  localparam int CTRL_CLR  = 1;

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rxState_t;

  // Line conditioning: index 0 is the PS/2 clock, index 1 is data.
  logic [1:0]    w_pins;
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_clkFiltD;
  logic          w_strobe;
  logic          w_datBit;

  rxState_t      r_state, w_stateNext;
  logic [2:0]    r_bitCnt, w_bitCntNext;
  logic [7:0]    r_shift, w_shiftNext;
  logic          r_parBit, w_parBitNext;
  logic [TW-1:0] r_tmoCnt;
  logic          w_push;
  logic          w_setPerr;
  logic          w_setFerr;

  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_rdAccess;
  logic          w_ctrlWr;
  logic          w_clr;
  logic          w_ovrSet;
  logic [7:0]    w_status;
  logic          w_unusedDin;

  logic          r_ovr;
  logic          r_perr;
  logic          r_ferr;
  logic          r_ien;
  logic          r_irq;
  logic [7:0]    r_dout;

  assign w_pins      = {ps2_dat, ps2_clk};
  assign w_strobe    = r_clkFiltD & ~r_filt[0];
  assign w_datBit    = r_filt[1];
  assign w_unusedDin = ^din[7:2];

  // A line only changes after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta     <= 2'b11;
      r_sync     <= 2'b11;
      r_filt     <= 2'b11;
      r_fcnt[0]  <= '0;
      r_fcnt[1]  <= '0;
      r_clkFiltD <= 1'b1;
    end else begin
      r_meta     <= w_pins;
      r_sync     <= r_meta;
      r_clkFiltD <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FILT_MAX) begin
          r_filt[i] <= r_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parBit <= 1'b0;
      r_tmoCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_parBit <= w_parBitNext;
      if (r_state == ST_IDLE || w_strobe) r_tmoCnt <= '0;
      else if (r_tmoCnt != TMO_MAX)       r_tmoCnt <= r_tmoCnt + TW'(1);
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_parBitNext = r_parBit;
    w_push       = 1'b0;
    w_setPerr    = 1'b0;
    w_setFerr    = 1'b0;
    if (r_state != ST_IDLE && !w_strobe && r_tmoCnt == TMO_MAX) begin
      w_stateNext = ST_IDLE;
      w_setFerr   = 1'b1;
    end else if (w_strobe) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_datBit) begin
            w_stateNext  = ST_DATA;
            w_bitCntNext = '0;
          end
        end
        ST_DATA: begin
          w_shiftNext  = {w_datBit, r_shift[7:1]};
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) w_stateNext = ST_PARITY;
        end
        ST_PARITY: begin
          w_parBitNext = w_datBit;
          w_stateNext  = ST_STOP;
        end
        ST_STOP: begin
          // Odd parity: data bits plus parity bit must XOR to one.
          if (^{r_shift, r_parBit}) begin
            if (w_datBit) w_push = 1'b1;
          end else begin
            w_setPerr = 1'b1;
          end
          if (!w_datBit) w_setFerr = 1'b1;
          w_stateNext = ST_IDLE;
        end
        default: w_stateNext = ST_IDLE;
      endcase
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (r_shift),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_rdAccess = cs & ~we;
  assign w_pop      = w_rdAccess & rs & rdy & ~w_empty;
  assign w_ctrlWr   = cs & we & ~rs;
  assign w_clr      = w_ctrlWr & din[CTRL_CLR];
  assign w_ovrSet   = w_push & w_full;

  always_comb begin
    w_status            = '0;
    w_status[STAT_NE]   = ~w_empty;
    w_status[STAT_OVR]  = r_ovr;
    w_status[STAT_PERR] = r_perr;
    w_status[STAT_FERR] = r_ferr;
    w_status[STAT_IEN]  = r_ien;
    w_status[STAT_IRQ]  = r_irq;
  end

  // Clearing loses to a same-cycle set so no event can be missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ien  <= 1'b0;
      r_irq  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_ovr  <= (r_ovr  & ~w_clr) | w_ovrSet;
      r_perr <= (r_perr & ~w_clr) | w_setPerr;
      r_ferr <= (r_ferr & ~w_clr) | w_setFerr;
      if (w_ctrlWr) r_ien <= din[CTRL_IEN];
      r_irq  <= r_ien & (~w_empty | r_ovr | r_perr | r_ferr);
      if (w_rdAccess) r_dout <= rs ? (w_empty ? 8'h00 : w_head) : w_status;
    end
  end

  assign dout = r_dout;
  assign irq  = r_irq;

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed bench for ps2_kbd: frames are bit-banged on the PS/2 pins
// and results are read back through the CPU register port.
`timescale 1ns/1ps
module tb_ps2_kbd;

  localparam int HALF = 20;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       we;
  logic       rs;
  logic       rdy;
  logic [7:0] din;
  logic [7:0] dout;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       irq;

  int total = 0;
  int bad   = 0;

  ps2_kbd #(
    .FIFO_DEPTH (8),
    .FILT_LEN   (8),
    .TIMEOUT    (16000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .we      (we),
    .rs      (rs),
    .rdy     (rdy),
    .din     (din),
    .dout    (dout),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends the first nBits of a frame; glitchAt inserts a 2-cycle clock dip.
  task automatic sendFrame(input logic [7:0] b, input logic badPar,
                           input logic stopBit, input int nBits,
                           input int glitchAt, input int tail);
    logic [10:0] bits;
    bits = {stopBit, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk);
      ps2_dat = bits[i];
      repeat (HALF) @(negedge clk);
      if (i == glitchAt) begin
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (tail) @(negedge clk);
  endtask

  task automatic cpuRead(input logic r, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; rs = r; rdy = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  task automatic cpuWrite(input logic r, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; rs = r; din = d; rdy = 1'b1;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; din = 8'h00;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    total++;
    if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", d); end
  endtask

  task automatic test_good_frame;
    logic [7:0] d;
    sendFrame(8'h1C, 1'b0, 1'b1, 11, -1, 40);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL good_status got=%h exp=01", d); end
    cpuRead(1'b1, d);
    total++;
    if (d !== 8'h1C) begin bad++; $display("FAIL good_data got=%h exp=1c", d); end
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL good_status_after got=%h exp=00", d); end
  endtask

  task automatic test_parity_error;
    logic [7:0] d;
    sendFrame(8'h1C, 1'b1, 1'b1, 11, -1, 40);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h04) begin bad++; $display("FAIL perr_status got=%h exp=04", d); end
    cpuWrite(1'b0, 8'h02);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL perr_clear got=%h exp=00", d); end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    for (int i = 1; i <= 9; i++) sendFrame(8'(i), 1'b0, 1'b1, 11, -1, 40);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h03) begin bad++; $display("FAIL ovr_status got=%h exp=03", d); end
    for (int i = 1; i <= 8; i++) begin
      cpuRead(1'b1, d);
      total++;
      if (d !== 8'(i)) begin bad++; $display("FAIL ovr_data%0d got=%h exp=%h", i, d, 8'(i)); end
    end
    cpuRead(1'b1, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL ovr_empty_data got=%h exp=00", d); end
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h02) begin bad++; $display("FAIL ovr_status_empty got=%h exp=02", d); end
    cpuWrite(1'b0, 8'h02);
  endtask

  task automatic test_timeout;
    logic [7:0] d;
    sendFrame(8'hFF, 1'b0, 1'b1, 6, -1, 40);
    repeat (16100) @(negedge clk);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h08) begin bad++; $display("FAIL tmo_status got=%h exp=08", d); end
    cpuWrite(1'b0, 8'h02);
    sendFrame(8'h5A, 1'b0, 1'b1, 11, -1, 40);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL tmo_next_status got=%h exp=01", d); end
    cpuRead(1'b1, d);
    total++;
    if (d !== 8'h5A) begin bad++; $display("FAIL tmo_next_data got=%h exp=5a", d); end
  endtask

  task automatic test_irq_stall;
    logic [7:0] d;
    bit seen;
    cpuWrite(1'b0, 8'h01);
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
    sendFrame(8'h11, 1'b0, 1'b1, 10, -1, 0);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (irq === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL irq_rise got=0 exp=1 within 40 cycles"); end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    sendFrame(8'h22, 1'b0, 1'b1, 11, -1, 40);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'hC1) begin bad++; $display("FAIL irq_status got=%h exp=c1", d); end
    @(negedge clk);
    cs = 1'b1; we = 1'b0; rs = 1'b1; rdy = 1'b0;
    repeat (3) @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    total++;
    if (dout !== 8'h11) begin bad++; $display("FAIL stall_data got=%h exp=11", dout); end
    cpuRead(1'b1, d);
    total++;
    if (d !== 8'h22) begin bad++; $display("FAIL stall_second got=%h exp=22", d); end
    repeat (2) @(negedge clk);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h40) begin bad++; $display("FAIL stall_status got=%h exp=40", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
    cpuWrite(1'b0, 8'h00);
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    sendFrame(8'hA5, 1'b0, 1'b1, 11, 4, 40);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL glitch_status got=%h exp=01", d); end
    cpuRead(1'b1, d);
    total++;
    if (d !== 8'hA5) begin bad++; $display("FAIL glitch_data got=%h exp=a5", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    cpuWrite(1'b0, 8'h01);
    sendFrame(8'h3C, 1'b0, 1'b1, 11, -1, 40);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'hC1) begin bad++; $display("FAIL pre_reset_status got=%h exp=c1", d); end
    sendFrame(8'h00, 1'b0, 1'b1, 4, -1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dout !== 8'h00) begin bad++; $display("FAIL async_rst_dout got=%h exp=00", dout); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL async_rst_irq got=%b exp=0", irq); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    cpuRead(1'b0, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL post_reset_status got=%h exp=00", d); end
    sendFrame(8'h3A, 1'b0, 1'b1, 11, -1, 40);
    cpuRead(1'b1, d);
    total++;
    if (d !== 8'h3A) begin bad++; $display("FAIL post_reset_data got=%h exp=3a", d); end
  endtask

  initial begin
    rst_n   = 1'b0;
    cs      = 1'b0;
    we      = 1'b0;
    rs      = 1'b0;
    rdy     = 1'b1;
    din     = 8'h00;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset;
    test_good_frame;
    test_parity_error;
    test_overflow;
    test_timeout;
    test_irq_stall;
    test_glitch;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
